// File: rtl/irq_stim_gen.sv
// Interrupt stimulus generator and run monitor: LFSR-timed, idle-gated round-robin requests
// plus halt/stack-overflow completion flags. Optional ack timeout: IRQ_ACK_TIMEOUT_EN.
module irq_stim_gen #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned CNT_WIDTH   = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS   = 16'hB400,
  parameter int unsigned PMD_SIZE    = 32,
  parameter logic [9:0]  HALT_OP     = 10'b0000000001,
  parameter int unsigned HALT_DELAY  = 10,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                idle_i,
  input  logic [PMD_SIZE-1:0] pm_op,
  input  logic                stck_ovf,
  input  logic [NUM_IRQ-1:0]  irq_en,
  input  logic [NUM_IRQ-1:0]  irq_ack,
  output logic [NUM_IRQ-1:0]  irq,
  output logic                done,
  output logic                err_ovf,
  output logic                err_ack
);

  localparam int unsigned PtrW  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned HaltW = $clog2(HALT_DELAY + 1);

  typedef enum logic [1:0] {StLoad, StCount, StAssert, StHalted} state_e;

  state_e               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [NUM_IRQ-1:0]   irq_q, irq_d;
  logic                 done_q, done_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 halt_armed_q, halt_armed_d;
  logic [HaltW-1:0]     halt_cnt_q, halt_cnt_d;
  logic                 halt_match, halt_expire;
  logic                 grant_vld;
  logic [PtrW-1:0]      grant_ch, cand;
  logic                 unused_pm_op;

  assign unused_pm_op = ^pm_op[PMD_SIZE-11:0];

`ifdef IRQ_ACK_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_ack_q, err_ack_d;
  assign err_ack = err_ack_q;
`else
  localparam int unsigned unused_ack_timeout = ACK_TIMEOUT;
  assign err_ack = 1'b0;
`endif

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  // Halt countdown arms once on the first match; later matches are ignored.
  assign halt_match  = (pm_op[PMD_SIZE-1 -: 10] == HALT_OP);
  assign halt_expire = halt_armed_q && (halt_cnt_q == '0);

  always_comb begin
    halt_armed_d = halt_armed_q;
    halt_cnt_d   = halt_cnt_q;
    if (!halt_armed_q) begin
      if (halt_match && !done_q) begin
        halt_armed_d = 1'b1;
        halt_cnt_d   = HaltW'(HALT_DELAY - 1);
      end
    end else if (halt_cnt_q != '0) begin
      halt_cnt_d = halt_cnt_q - HaltW'(1);
    end
  end

  assign err_ovf_d = err_ovf_q | stck_ovf;
  assign done_d    = done_q | stck_ovf | halt_expire;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_IRQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % NUM_IRQ);
      if (!grant_vld && irq_en[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    irq_d   = irq_q;
`ifdef IRQ_ACK_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_ack_d = err_ack_q;
`endif
    if (done_d) begin
      state_d = StHalted;
      irq_d   = '0;
    end else begin
      case (state_q)
        StLoad: begin
          cnt_d   = lfsr_q[CNT_WIDTH-1:0];
          state_d = StCount;
        end
        StCount: begin
          if (idle_i) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_WIDTH'(1);
            end else if (grant_vld) begin
              irq_d           = '0;
              irq_d[grant_ch] = 1'b1;
              ptr_d           = grant_ch;
              state_d         = StAssert;
`ifdef IRQ_ACK_TIMEOUT_EN
              tmo_d           = '0;
`endif
            end
          end
        end
        StAssert: begin
          if (irq_ack[ptr_q]) begin
            irq_d   = '0;
            state_d = StLoad;
          end
`ifdef IRQ_ACK_TIMEOUT_EN
          else if (tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
            irq_d     = '0;
            err_ack_d = 1'b1;
            state_d   = StLoad;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
`endif
        end
        StHalted: ;
        default: state_d = StLoad;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StLoad;
      lfsr_q       <= LFSR_SEED;
      cnt_q        <= '0;
      ptr_q        <= PtrW'(NUM_IRQ - 1);
      irq_q        <= '0;
      done_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      halt_armed_q <= 1'b0;
      halt_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      irq_q        <= irq_d;
      done_q       <= done_d;
      err_ovf_q    <= err_ovf_d;
      halt_armed_q <= halt_armed_d;
      halt_cnt_q   <= halt_cnt_d;
    end
  end

`ifdef IRQ_ACK_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q     <= '0;
      err_ack_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      err_ack_q <= err_ack_d;
    end
  end
`endif

  assign irq     = irq_q;
  assign done    = done_q;
  assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_irq_stim_gen.sv
// Directed bench for irq_stim_gen: grant order/latency scoreboard, idle gating, halt and
// overflow completion, async reset, and ack timeout when IRQ_ACK_TIMEOUT_EN is defined.
module tb_irq_stim_gen;

  localparam logic [31:0] HaltPat = 32'h0040_0000;
`ifdef IRQ_ACK_TIMEOUT_EN
  localparam int HoldChk = 5;
`else
  localparam int HoldChk = 9;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        idle_i;
  logic [31:0] pm_op;
  logic        stck_ovf;
  logic [3:0]  irq_en;
  logic [3:0]  irq_ack;
  logic [3:0]  irq;
  logic        done;
  logic        err_ovf;
  logic        err_ack;

  typedef struct {
    int ch;
    int lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr;

  irq_stim_gen dut (
    .clk      (clk),
    .reset    (reset),
    .idle_i   (idle_i),
    .pm_op    (pm_op),
    .stck_ovf (stck_ovf),
    .irq_en   (irq_en),
    .irq_ack  (irq_ack),
    .irq      (irq),
    .done     (done),
    .err_ovf  (err_ovf),
    .err_ack  (err_ack)
  );

  always #5 clk = ~clk;

  // Reference 16-bit Galois LFSR, seed ACE1, taps B400.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input int lat);
    exp_t e;
    e.ch  = ch;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Called at a negedge with irq low; counts edges until a request shows up.
  task automatic wait_grant();
    exp_t        e;
    int          n;
    logic [31:0] one;
    e   = sb.pop_front();
    n   = 0;
    one = 1;
    do begin
      @(negedge clk);
      n++;
    end while (irq == 4'b0000 && n < 40);
    check("grant_lat", n, e.lat);
    check("grant_ch", {28'b0, irq}, one << e.ch);
  endtask

  // Foreign acks must be ignored; the real ack drops irq on the next edge.
  task automatic ack_next(input int cur, input int nxt);
    logic [3:0] oh;
    oh = 4'(1 << cur);
    irq_ack = ~oh;
    @(negedge clk);
    check("foreign_ack_hold", {28'b0, irq}, {28'b0, oh});
    irq_ack = oh;
    @(negedge clk);
    irq_ack = 4'b0000;
    check("ack_drop", {28'b0, irq}, 32'h0);
    // LOAD on the next edge takes the current LFSR low bits, then k decrements, then grant.
    push(nxt, int'(m_lfsr[2:0]) + 2);
    wait_grant();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_irq", {28'b0, irq}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_err_ovf", {31'b0, err_ovf}, 32'h0);
    check("rst_err_ack", {31'b0, err_ack}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_i   = 1'b0;
    pm_op    = '0;
    stck_ovf = 1'b0;
    irq_en   = 4'hF;
    irq_ack  = 4'h0;

    // Idle gating: first LOAD gives cnt=1, which must hold while idle is low.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_low_no_irq", {28'b0, irq}, 32'h0);
    end
    idle_i = 1'b1;
    push(0, 2);
    wait_grant();

    // Full round robin with all channels enabled; first grant on edge 3.
    do_reset();
    push(0, 3);
    wait_grant();
    ack_next(0, 1);
    ack_next(1, 2);
    ack_next(2, 3);
    ack_next(3, 0);

    // Enable change while asserting is ignored; then only channels 1 and 3 are granted.
    irq_en = 4'b1010;
    ack_next(0, 1);
    ack_next(1, 3);
    ack_next(3, 1);

    // Halt: done 10 edges after the first match; a second match must not restart it.
    irq_en = 4'hF;
    pm_op  = HaltPat;
    @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      pm_op = (i == 3) ? HaltPat : 32'h0;
      @(negedge clk);
      check("halt_not_yet", {31'b0, done}, 32'h0);
      if (i <= HoldChk) check("halt_irq_held", {28'b0, irq}, 32'h2);
    end
    pm_op = '0;
    @(negedge clk);
    check("halt_done", {31'b0, done}, 32'h1);
    check("halt_irq_off", {28'b0, irq}, 32'h0);
    check("halt_no_ovf", {31'b0, err_ovf}, 32'h0);
    irq_ack = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      irq_ack = ~irq_ack;
      check("halted_irq_off", {28'b0, irq}, 32'h0);
    end
    irq_ack = 4'h0;
    check("halted_done_sticky", {31'b0, done}, 32'h1);

    // Stack overflow overrides a pending halt countdown while irq[2] is held.
    do_reset();
    push(0, 3);
    wait_grant();
    ack_next(0, 1);
    ack_next(1, 2);
    pm_op = HaltPat;
    @(negedge clk);
    pm_op = '0;
    @(negedge clk);
    check("ovf_pre_done", {31'b0, done}, 32'h0);
    check("ovf_pre_irq", {28'b0, irq}, 32'h4);
    stck_ovf = 1'b1;
    @(negedge clk);
    stck_ovf = 1'b0;
    check("ovf_err", {31'b0, err_ovf}, 32'h1);
    check("ovf_done", {31'b0, done}, 32'h1);
    check("ovf_irq_off", {28'b0, irq}, 32'h0);
    check("ovf_no_err_ack", {31'b0, err_ack}, 32'h0);
    @(negedge clk);
    check("ovf_err_sticky", {31'b0, err_ovf}, 32'h1);

`ifdef IRQ_ACK_TIMEOUT_EN
    // Ack on the 8th edge wins over the timeout.
    do_reset();
    push(0, 3);
    wait_grant();
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check("tmo_hold0", {28'b0, irq}, 32'h1);
    end
    irq_ack = 4'b0001;
    @(negedge clk);
    irq_ack = 4'b0000;
    check("tmo_ack_wins_irq", {28'b0, irq}, 32'h0);
    check("tmo_ack_wins_err", {31'b0, err_ack}, 32'h0);
    push(1, int'(m_lfsr[2:0]) + 2);
    wait_grant();
    // No ack: irq high exactly 8 cycles, then err_ack and the next channel.
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check("tmo_hold1", {28'b0, irq}, 32'h2);
    end
    @(negedge clk);
    check("tmo_irq_off", {28'b0, irq}, 32'h0);
    check("tmo_err_ack", {31'b0, err_ack}, 32'h1);
    check("tmo_no_done", {31'b0, done}, 32'h0);
    push(2, int'(m_lfsr[2:0]) + 2);
    wait_grant();
`endif

    // Reset mid-request drops irq asynchronously.
    do_reset();
    push(0, 3);
    wait_grant();
    #2;
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
